// File: rtl/truth_table_checker.sv
// ============================================================================
// Module   : truth_table_checker
// Brief    : Checks observed 2-input gate vectors against a truth table and
//            reports coverage and mismatch count. Optional FIRST_FAIL_CAPTURE_EN
//            adds a fail_vec port that holds the first mismatching vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker #(
    parameter logic [3:0] TT    = 4'b1001,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_y,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
`ifdef FIRST_FAIL_CAPTURE_EN
    output logic [2:0]       fail_vec,
`endif
    output logic [3:0]       coverage
);

    localparam logic [1:0]       c_S_IDLE  = 2'd0;
    localparam logic [1:0]       c_S_RUN   = 2'd1;
    localparam logic [1:0]       c_S_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] c_ERR_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic             pass_q, pass_d;
    logic             w_accept;
    logic             w_mismatch;
    logic [1:0]       w_idx;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [2:0]       fv_q, fv_d;
`endif

    assign w_idx      = {in_a, in_b};
    assign w_accept   = in_valid && (state_q == c_S_RUN);
    assign w_mismatch = (in_y != TT[w_idx]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_S_IDLE;
            err_q   <= '0;
            cov_q   <= '0;
            pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fv_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            pass_q  <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
            fv_q    <= fv_d;
`endif
        end
    end

    // Run datapath: clear on start, accumulate on accepted vectors
    always_comb begin
        err_d  = err_q;
        cov_d  = cov_q;
        pass_d = pass_q;
`ifdef FIRST_FAIL_CAPTURE_EN
        fv_d   = fv_q;
`endif
        if ((state_q != c_S_RUN) && start) begin
            err_d  = '0;
            cov_d  = '0;
            pass_d = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fv_d   = '0;
`endif
        end else if (w_accept) begin
            cov_d[w_idx] = 1'b1;
            if (w_mismatch && (err_q != c_ERR_MAX)) begin
                err_d = err_q + 1'b1;
            end
`ifdef FIRST_FAIL_CAPTURE_EN
            // err_q only ever grows within a run, so zero means no earlier miss
            if (w_mismatch && (err_q == '0)) begin
                fv_d = {in_a, in_b, in_y};
            end
`endif
            if (cov_d == 4'hF) begin
                pass_d = (err_d == '0);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: if (start) state_d = c_S_RUN;
            c_S_RUN:  if (w_accept && (cov_d == 4'hF)) state_d = c_S_DONE;
            c_S_DONE: if (start) state_d = c_S_RUN;
            default:  state_d = c_S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy     = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            c_S_RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            c_S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign err_cnt  = err_q;
    assign coverage = cov_q;
    assign pass     = pass_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    assign fail_vec = fv_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// Module   : tb_truth_table_checker
// Brief    : Scoreboard bench; two checker instances (XNOR/8-bit and
//            XOR/2-bit) share stimulus and are checked against a run model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

    localparam logic [3:0] TT0 = 4'b1001;
    localparam logic [3:0] TT1 = 4'b0110;
    localparam int MAX0 = 255;
    localparam int MAX1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, in_y = 1'b0;

    logic       rdy0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [3:0] cov0;
    logic       rdy1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [3:0] cov1;
    logic [2:0] fv0, fv1;

    always #5 clk = ~clk;

    truth_table_checker #(.TT(TT0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_y(in_y), .in_ready(rdy0), .busy(busy0),
        .done(done0), .pass(pass0), .err_cnt(err0),
`ifdef FIRST_FAIL_CAPTURE_EN
        .fail_vec(fv0),
`endif
        .coverage(cov0));

    truth_table_checker #(.TT(TT1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_y(in_y), .in_ready(rdy1), .busy(busy1),
        .done(done1), .pass(pass1), .err_cnt(err1),
`ifdef FIRST_FAIL_CAPTURE_EN
        .fail_vec(fv1),
`endif
        .coverage(cov1));

`ifndef FIRST_FAIL_CAPTURE_EN
    assign fv0 = 3'b000;
    assign fv1 = 3'b000;
`endif

    typedef struct {
        bit       run;
        bit       fin;
        bit       pass0;
        bit       pass1;
        int       err0;
        int       err1;
        bit [3:0] cov;
        bit [2:0] fv0;
        bit [2:0] fv1;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge with the inputs presented
    task automatic model_step(input bit st, input bit v, input bit a, input bit b, input bit y);
        int idx;
        bit e0, e1;
        if (!rst_n) begin
            m = '{default: 0};
        end else if (m.run) begin
            if (v) begin
                idx = a * 2 + b;
                e0 = TT0[idx];
                e1 = TT1[idx];
                if (y != e0) begin
                    if (m.err0 == 0) m.fv0 = {a, b, y};
                    if (m.err0 < MAX0) m.err0++;
                end
                if (y != e1) begin
                    if (m.err1 == 0) m.fv1 = {a, b, y};
                    if (m.err1 < MAX1) m.err1++;
                end
                m.cov[idx] = 1'b1;
                if (m.cov == 4'hF) begin
                    m.run = 0;
                    m.fin = 1;
                    m.pass0 = (m.err0 == 0);
                    m.pass1 = (m.err1 == 0);
                end
            end
        end else if (st) begin
            m = '{default: 0};
            m.run = 1;
        end
    endtask

    task automatic step(input bit st, input bit v, input bit a, input bit b, input bit y);
        @(negedge clk);
        #1;
        start = st; in_valid = v; in_a = a; in_b = b; in_y = y;
        model_step(st, v, a, b, y);
        sb.push_back(m);
    endtask

    task automatic vec(input bit a, input bit b, input bit y);
        step(1'b0, 1'b1, a, b, y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge
    task automatic async_reset;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        start = 0; in_valid = 0;
        #1;
        chk("async_busy0", {7'b0, busy0}, 8'd0);
        chk("async_rdy0", {7'b0, rdy0}, 8'd0);
        chk("async_done0", {7'b0, done0}, 8'd0);
        chk("async_err0", err0, 8'd0);
        chk("async_cov0", {4'b0, cov0}, 8'd0);
        chk("async_pass1", {7'b0, pass1}, 8'd0);
        chk("async_err1", {6'b0, err1}, 8'd0);
        model_step(0, 0, 0, 0, 0);
        sb.push_back(m);
        idle(1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per cycle and compares every output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("busy0", {7'b0, busy0}, {7'b0, e.run});
                chk("rdy0", {7'b0, rdy0}, {7'b0, e.run});
                chk("done0", {7'b0, done0}, {7'b0, e.fin});
                chk("busy1", {7'b0, busy1}, {7'b0, e.run});
                chk("rdy1", {7'b0, rdy1}, {7'b0, e.run});
                chk("done1", {7'b0, done1}, {7'b0, e.fin});
                chk("pass0", {7'b0, pass0}, {7'b0, e.pass0});
                chk("pass1", {7'b0, pass1}, {7'b0, e.pass1});
                chk("err0", err0, e.err0[7:0]);
                chk("err1", {6'b0, err1}, e.err1[7:0]);
                chk("cov0", {4'b0, cov0}, {4'b0, e.cov});
                chk("cov1", {4'b0, cov1}, {4'b0, e.cov});
`ifdef FIRST_FAIL_CAPTURE_EN
                chk("fv0", {5'b0, fv0}, {5'b0, e.fv0});
                chk("fv1", {5'b0, fv1}, {5'b0, e.fv1});
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, b, y;
        int cyc;
        m = '{default: 0};
        idle(2);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // In_valid without start stays idle
        for (int i = 0; i < 3; i++) vec(1'b1, 1'b0, 1'b0);

        // Correct XNOR run
        step(1, 0, 0, 0, 0);
        vec(0, 0, 1); vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 1);
        idle(2);

        // One mismatch on 01
        step(1, 0, 0, 0, 0);
        vec(0, 0, 1); vec(0, 1, 1); vec(1, 0, 0); vec(1, 1, 1);
        idle(1);

        // Repeats and a valid gap; start during RUN ignored
        step(1, 0, 0, 0, 0);
        vec(0, 0, 1); vec(0, 0, 1); step(1, 1, 1, 1, 1); vec(0, 1, 0);
        idle(2);
        vec(1, 0, 0);
        idle(1);

        // Six mismatches, 11 last
        step(1, 0, 0, 0, 0);
        vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 1); vec(0, 0, 0); vec(0, 1, 1); vec(1, 1, 0);
        idle(1);

        // Correct XOR responses, then restart from DONE
        step(1, 0, 0, 0, 0);
        vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);
        step(1, 0, 0, 0, 0);
        idle(1);

        // Saturate the 8-bit counter
        for (int i = 0; i < 260; i++) vec(0, 0, 1'b0);
        for (int i = 0; i < 10; i++) vec(0, 0, 1'b1);
        vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 0);
        idle(1);

        // Reset mid-run after two accepts
        step(1, 0, 0, 0, 0);
        vec(0, 0, 1); vec(1, 1, 1);
        async_reset();
        for (int i = 0; i < 2; i++) vec(0, 1, 0);

        // Randomised runs
        for (int r = 0; r < 40; r++) begin
            step(1, 0, 0, 0, 0);
            cyc = 0;
            while (m.run && cyc < 60) begin
                a = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
                y = ($urandom_range(0, 99) < 80) ? TT0[{a, b}] : ~TT0[{a, b}];
                step(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), a, b, y);
                cyc++;
                if (r % 13 == 5 && cyc == 3) async_reset();
            end
            for (int i = 0; i < 2; i++)
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        idle(2);
        @(negedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
